// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit slice per stage with the
// carry registered between stages, valid/ready on both sides, global-enable stall.
module addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  logic stall;
  logic en;

  assign stall    = out_valid && !out_ready;
  assign en       = !stall;
  assign in_ready = !rst && !stall;

  // Operands are forwarded already right-shifted, so each stage always adds the
  // low CHUNK bits of what it receives; the partial sum grows by one slice per stage.
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    localparam int RW = WIDTH - g * CHUNK;

    logic [RW-1:0]            a_i;
    logic [RW-1:0]            b_i;
    logic                     c_i;
    logic                     sub_i;
    logic                     v_i;
    logic [CHUNK:0]           slice;
    logic [(g+1)*CHUNK-1:0]   s_n;
    logic [(g+1)*CHUNK-1:0]   s_q;
    logic                     v_q;

    if (g == 0) begin : g_in
      assign a_i   = a;
      assign b_i   = op[0] ? ~b : b;
      assign c_i   = op[1] ? (cin ^ op[0]) : op[0];
      assign sub_i = op[0];
      assign v_i   = in_valid && in_ready;
      assign s_n   = slice[CHUNK-1:0];
    end else begin : g_link
      assign a_i   = g_stage[g-1].g_fwd.a_q;
      assign b_i   = g_stage[g-1].g_fwd.b_q;
      assign c_i   = g_stage[g-1].g_fwd.c_q;
      assign sub_i = g_stage[g-1].g_fwd.sub_q;
      assign v_i   = g_stage[g-1].v_q;
      assign s_n   = {slice[CHUNK-1:0], g_stage[g-1].s_q};
    end

    assign slice = {1'b0, a_i[CHUNK-1:0]} + {1'b0, b_i[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_i};

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        s_q <= '0;
      end else if (en) begin
        v_q <= v_i;
        s_q <= s_n;
      end
    end

    if (g < LAST) begin : g_fwd
      logic [RW-CHUNK-1:0] a_q;
      logic [RW-CHUNK-1:0] b_q;
      logic                c_q;
      logic                sub_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q   <= '0;
          b_q   <= '0;
          c_q   <= 1'b0;
          sub_q <= 1'b0;
        end else if (en) begin
          a_q   <= a_i[RW-1:CHUNK];
          b_q   <= b_i[RW-1:CHUNK];
          c_q   <= slice[CHUNK];
          sub_q <= sub_i;
        end
      end
    end else begin : g_out
      logic cout_q;
      logic ovf_q;
      logic zero_q;

      // In the last stage the top slice bit of a_i/b_i is the operand MSB.
      always_ff @(posedge clk) begin
        if (rst) begin
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (en) begin
          cout_q <= slice[CHUNK] ^ sub_i;
          ovf_q  <= (a_i[CHUNK-1] == b_i[CHUNK-1]) && (slice[CHUNK-1] != a_i[CHUNK-1]);
          zero_q <= (s_n == '0);
        end
      end
    end
  end

  assign out_valid = g_stage[LAST].v_q;
  assign result    = g_stage[LAST].s_q;
  assign cout      = g_stage[LAST].g_out.cout_q;
  assign ovf       = g_stage[LAST].g_out.ovf_q;
  assign zero      = g_stage[LAST].g_out.zero_q;
  assign neg       = g_stage[LAST].s_q[WIDTH-1];

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined successor to the team's 8-bit combinational adder/subtractor.
- Splits a WIDTH-bit add/subtract into CHUNK-bit slices, one slice per pipeline stage, with the carry registered between stages.
- Accepts one operation per cycle, supports carry/borrow-in chaining, and produces carry/borrow, signed overflow, zero and negative flags.
- Sits between operand registers and the datapath writeback, using a valid/ready handshake on both sides.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per pipeline stage; STAGES = WIDTH/CHUNK (minimum 1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- op  input  2  00 A+B, 01 A-B, 10 A+B+cin, 11 A-B-cin.
- cin  input  1  carry-in (op 10) or borrow-in (op 11); ignored for op 00/01.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result beat.
- result  output  WIDTH  sum or difference, modulo 2^WIDTH.
- cout  output  1  add: carry out of MSB; sub: borrow (1 when the unsigned A < B + borrow-in).
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  result == 0.
- neg  output  1  result[WIDTH-1].

Behaviour:
- Reset: every valid bit in the pipeline clears. All outputs then read 0: out_valid, result, cout, ovf, zero, neg. in_ready reads 1 in the cycle after reset deasserts.
- While rst is high, in_ready = 0 and beats are dropped. Reset mid-operation discards all in-flight beats; nothing is emitted afterwards.
- Accept rule: a beat is accepted when in_valid && in_ready at a rising edge. Transfer rule: a result transfers when out_valid && out_ready.
- Stall: stall = out_valid && !out_ready. in_ready = !stall (combinational).
  - On stall, every stage holds: data, carries and valids are frozen, and out_valid and all result fields stay stable until transfer.
  - Bubbles are not compressed; the pipeline is a simple global-enable design.
- Latency: STAGES cycles from accept to out_valid, given no stall. Throughput is 1 beat/cycle. For STAGES = 1 the result is registered once.
- Operand conditioning at stage 0:
  - Effective B is b for add, ~b for sub.
  - Carry-in: op00 = 0, op01 = 1, op10 = cin, op11 = ~cin.
  - a, effective B and op are carried down the pipeline alongside the partial result.
- Stage k (0..STAGES-1):
  - Adds slice k of A and effective B plus the registered carry from stage k-1 (stage 0 uses the conditioned carry-in).
  - Registers the CHUNK-bit sum slice and the carry-out.
  - Upper slices travel unchanged until their stage.
- Final flags, computed in the last stage from the full result:
  - cout = final carry for add; inverted final carry for sub.
  - ovf = (a[MSB] == effB[MSB]) && (result[MSB] != a[MSB]).
  - zero and neg as defined under Ports.
- Widths: no sign extension; result wraps modulo 2^WIDTH. Out-of-range or reserved encodings do not exist, since all 4 op values are defined.
- Simultaneous accept and transfer in the same cycle is legal and is the normal streaming case.
- in_valid with in_ready = 0: the beat is not taken. The source holds a, b, op and cin stable until it is accepted.

Test Plan (WIDTH=16, CHUNK=8, latency 2):
- Reset check: assert rst for 3 cycles with in_valid=1 -> out_valid=0 and all outputs 0 throughout; in_ready=1 one cycle after release.
- Cross-chunk carry: op00, a=0x00FF, b=0x0001 -> 2 cycles later result=0x0100, cout=0, ovf=0, zero=0. Then a=0xFFFF, b=0x0001 -> result=0x0000, cout=1, zero=1.
- Subtract borrow and overflow:
  - op01, a=0x0003, b=0x0005 -> result=0xFFFE, cout=1, neg=1, ovf=0.
  - op01, a=0x8000, b=0x0001 -> result=0x7FFF, cout=0, ovf=1.
  - op00, a=0x7FFF, b=0x0001 -> result=0x8000, ovf=1.
- Chained ops:
  - op10, a=0x1234, b=0x0001, cin=1 -> result=0x1236.
  - op11, a=0x1234, b=0x0001, cin=1 -> result=0x1232, cout=0.
  - op11, a=0, b=0, cin=1 -> result=0xFFFF, cout=1.
- Backpressure: stream 6 back-to-back adds (i+i for i=1..6). Hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, outputs stable, and all 6 results 2,4,6,8,10,12 delivered in order with none lost or duplicated.
- Reset mid-flight: accept 2 beats, assert rst on the next edge -> neither result ever appears with out_valid=1; the next accepted beat emerges 2 cycles after accept.
